store_buffer: RTL and testbench

- Posted-write buffer between the data cache write path and the block-organised data memory.
- Accepts full 32-bit word stores (byte/half merging already done upstream) and queues them in a small FIFO.
- Drains entries to memory one per memory acknowledge.
- Forwards buffered data to loads so the MEM stage never reads stale memory; merges repeat stores to a queued non-head address.

---
 rtl/store_buffer_pkg.sv | 23 ++
 rtl/sb_match_unit.sv | 46 ++++
 rtl/store_buffer.sv | 128 ++++++++++++
 tb/tb_store_buffer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types for the posted-write store buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package store_buffer_pkg;

  localparam int SB_DATA_WIDTH    = 32;
  localparam int SB_ADDRESS_WIDTH = 30;
  localparam int SB_DEPTH_LOG2    = 2;
  localparam int SB_DEPTH         = 2 ** SB_DEPTH_LOG2;

  // One buffer slot; valid entries always form a contiguous run starting at head.
  typedef struct packed {
    logic                        valid;
    logic [SB_ADDRESS_WIDTH-1:0] address;
    logic [SB_DATA_WIDTH-1:0]    data;
  } sb_entry_t;

  typedef enum logic {
    SB_IDLE,
    SB_DRAIN
  } sb_state_t;

endpackage

// File: rtl/sb_match_unit.sv
// Address match: youngest-first load forwarding plus non-head merge lookup for stores.
// Latency: purely combinational.
// Backpressure: none; evaluates every cycle.
module sb_match_unit
  import store_buffer_pkg::*;
#(
  parameter int DATA_WIDTH    = SB_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = SB_ADDRESS_WIDTH,
  parameter int DEPTH_LOG2    = SB_DEPTH_LOG2
) (
  input  sb_entry_t [2**DEPTH_LOG2-1:0] entries,
  input  logic [DEPTH_LOG2-1:0]         head,
  input  logic [ADDRESS_WIDTH-1:0]      rd_address,
  input  logic [ADDRESS_WIDTH-1:0]      wr_address,
  output logic                          rd_hit,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          merge_hit,
  output logic [DEPTH_LOG2-1:0]         merge_index
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [DEPTH_LOG2-1:0] idx;

  // Walk from oldest (head) to youngest; later matches override, so the youngest wins.
  // The merge search skips distance 0 because the head may already be in flight.
  always_comb begin
    rd_hit      = 1'b0;
    rd_data     = '0;
    merge_hit   = 1'b0;
    merge_index = '0;
    idx         = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + DEPTH_LOG2'(k);
      if (entries[idx].valid && (entries[idx].address == rd_address)) begin
        rd_hit  = 1'b1;
        rd_data = entries[idx].data;
      end
      if ((k != 0) && entries[idx].valid && (entries[idx].address == wr_address)) begin
        merge_hit   = 1'b1;
        merge_index = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between cache write path and data memory, with forwarding and merging.
// Latency: accepted store visible to lookup and presented to memory the next cycle.
// Backpressure: wr_ready drops when full (registered, no bypass) or while flush is held.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DATA_WIDTH    = SB_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = SB_ADDRESS_WIDTH,
  parameter int DEPTH_LOG2    = SB_DEPTH_LOG2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDRESS_WIDTH-1:0] wr_address,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [ADDRESS_WIDTH-1:0] rd_address,
  output logic                     rd_hit,
  output logic [DATA_WIDTH-1:0]    rd_data,
  input  logic                     flush,
  output logic                     flush_done,
  output logic                     mem_write_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  input  logic                     mem_ack,
  output logic                     empty,
  output logic                     full
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);

  sb_entry_t [DEPTH-1:0]  entries_q;
  logic [DEPTH_LOG2-1:0]  head_q;
  logic [DEPTH_LOG2-1:0]  tail_q;
  logic [DEPTH_LOG2:0]    count_q;
  sb_state_t              state_q;
  sb_state_t              state_d;

  logic                   accept;
  logic                   do_merge;
  logic                   do_append;
  logic                   do_retire;
  logic                   merge_hit;
  logic [DEPTH_LOG2-1:0]  merge_index;

  sb_match_unit #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DEPTH_LOG2    (DEPTH_LOG2)
  ) u_match (
    .entries     (entries_q),
    .head        (head_q),
    .rd_address  (rd_address),
    .wr_address  (wr_address),
    .rd_hit      (rd_hit),
    .rd_data     (rd_data),
    .merge_hit   (merge_hit),
    .merge_index (merge_index)
  );

  assign full       = (count_q == COUNT_FULL);
  assign empty      = (count_q == '0);
  assign wr_ready   = !full && !flush;
  assign flush_done = flush && empty;

  assign accept    = wr_valid && wr_ready;
  assign do_merge  = accept && merge_hit;
  assign do_append = accept && !merge_hit;

  // Head entry is held on the memory port until acknowledged.
  assign mem_write_enable = (state_q == SB_DRAIN);
  assign mem_address      = entries_q[head_q].address;
  assign mem_write_data   = entries_q[head_q].data;
  assign do_retire        = mem_write_enable && mem_ack;

  // Drain state register; reset drops any in-flight write without retry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SB_IDLE;
    else     state_q <= state_d;
  end

  // Next state: leave IDLE on any append, return once the last entry retires with nothing arriving.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_IDLE:  if (do_append) state_d = SB_DRAIN;
      SB_DRAIN: if (do_retire && (count_q == COUNT_ONE) && !do_append) state_d = SB_IDLE;
      default:  state_d = SB_IDLE;
    endcase
  end

  // Head/tail pointers wrap naturally at DEPTH; count tracks net appends minus retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_append) tail_q <= tail_q + 1'b1;
      if (do_retire) head_q <= head_q + 1'b1;
      case ({do_append, do_retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage: retire clears head, append fills tail, merge rewrites a non-head slot.
  // These never collide: append is blocked when tail==head with entries present,
  // and merge targets are never the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q <= '0;
    end else begin
      if (do_retire) entries_q[head_q].valid <= 1'b0;
      if (do_append) begin
        entries_q[tail_q].valid   <= 1'b1;
        entries_q[tail_q].address <= wr_address;
        entries_q[tail_q].data    <= wr_data;
      end
      if (do_merge) entries_q[merge_index].data <= wr_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer against a queue-based reference model.
// Latency: model state is the pre-edge buffer contents, outputs sampled at negedge.
// Backpressure: model blocks stores when it holds four entries or flush is high.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [29:0] wr_address;
  logic [31:0] wr_data;
  logic [29:0] rd_address;
  logic        rd_hit;
  logic [31:0] rd_data;
  logic        flush;
  logic        flush_done;
  logic        mem_write_enable;
  logic [29:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_ack;
  logic        empty;
  logic        full;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .wr_address       (wr_address),
    .wr_data          (wr_data),
    .rd_address       (rd_address),
    .rd_hit           (rd_hit),
    .rd_data          (rd_data),
    .flush            (flush),
    .flush_done       (flush_done),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_ack          (mem_ack),
    .empty            (empty),
    .full             (full)
  );

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, check outputs against the model, then advance the model.
  task automatic step(input logic wv, input logic [29:0] wa, input logic [31:0] wd,
                      input logic [29:0] ra, input logic ack, input logic fl);
    int          sz;
    logic        exp_rdy;
    logic        exp_hit;
    logic [31:0] exp_rd;
    logic        merged;
    wr_valid   = wv;
    wr_address = wa;
    wr_data    = wd;
    rd_address = ra;
    mem_ack    = ack;
    flush      = fl;
    @(negedge clk);
    sz      = q.size();
    exp_rdy = (sz < 4) && !fl;
    exp_hit = 1'b0;
    exp_rd  = '0;
    for (int i = sz - 1; i >= 0; i--) begin
      if (q[i].a == ra) begin
        exp_hit = 1'b1;
        exp_rd  = q[i].d;
        break;
      end
    end
    chk("empty", empty, sz == 0);
    chk("full", full, sz == 4);
    chk("wr_ready", wr_ready, exp_rdy);
    chk("mem_we", mem_write_enable, sz > 0);
    chk("flush_done", flush_done, fl && (sz == 0));
    chk("rd_hit", rd_hit, exp_hit);
    chk("rd_data", rd_data, exp_rd);
    if (sz > 0) begin
      chk("mem_addr", mem_address, q[0].a);
      chk("mem_data", mem_write_data, q[0].d);
    end
    merged = 1'b0;
    if (wv && exp_rdy) begin
      for (int i = 1; i < sz; i++) begin
        if (q[i].a == wa) begin
          q[i].d = wd;
          merged = 1'b1;
        end
      end
      if (!merged) q.push_back('{a: wa, d: wd});
    end
    if (ack && (sz > 0)) void'(q.pop_front());
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges and check the asynchronous effect before the next edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_mem_we", mem_write_enable, 0);
    chk("rst_rd_hit", rd_hit, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_wr_ready", wr_ready, !flush);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    wr_valid   = 1'b0;
    wr_address = '0;
    wr_data    = '0;
    rd_address = '0;
    flush      = 1'b0;
    mem_ack    = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single store, held at memory port, forwarded to a load.
    step(1, 30'h100, 32'hDEADBEEF, 30'h100, 0, 0);
    chk("t1_empty", empty, 0);
    chk("t1_mem_we", mem_write_enable, 1);
    chk("t1_mem_addr", mem_address, 30'h100);
    chk("t1_rd_hit", rd_hit, 1);
    chk("t1_rd_data", rd_data, 32'hDEADBEEF);
    step(0, 0, 0, 30'h100, 0, 0);

    // Fill to full, fifth store refused, one ack frees a slot.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 30'h10 + 30'(i), 32'(i + 1), 0, 0, 0);
    chk("t2_full", full, 1);
    chk("t2_wr_ready", wr_ready, 0);
    step(1, 30'h99, 32'h55, 30'h99, 0, 0);
    chk("t2_no_accept", rd_hit, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("t2_full_after_ack", full, 0);
    chk("t2_next_addr", mem_address, 30'h11);

    // Merge into a queued non-head entry.
    do_reset();
    step(1, 30'h20, 32'd1, 0, 0, 0);
    step(1, 30'h21, 32'd2, 0, 0, 0);
    step(1, 30'h21, 32'd7, 30'h21, 0, 0);
    step(0, 0, 0, 30'h21, 1, 0);
    chk("t3_second_addr", mem_address, 30'h21);
    chk("t3_second_data", mem_write_data, 32'd7);
    step(0, 0, 0, 0, 1, 0);
    chk("t3_drained", empty, 1);

    // Repeat store to the head address appends instead of merging.
    do_reset();
    step(1, 30'h30, 32'd5, 0, 0, 0);
    step(1, 30'h30, 32'd9, 30'h30, 0, 0);
    step(0, 0, 0, 30'h30, 0, 0);
    chk("t4_fwd_youngest", rd_data, 32'd9);
    chk("t4_head_data", mem_write_data, 32'd5);
    step(0, 0, 0, 30'h30, 1, 0);
    chk("t4_second_data", mem_write_data, 32'd9);
    step(0, 0, 0, 30'h30, 1, 0);

    // Pointer wrap with an ack every cycle.
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 30'h40 + 30'(i), $urandom, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    chk("t5_empty", empty, 1);

    // Flush drains and reports completion; reset mid-drain discards entries.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 30'h50 + 30'(i), 32'(100 + i), 0, 0, 0);
    step(1, 30'h77, 32'h77, 30'h77, 0, 1);
    chk("t6_wr_ready", wr_ready, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1);
    chk("t6_flush_done", flush_done, 1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 30'h60, 32'd1, 0, 0, 0);
    step(1, 30'h61, 32'd2, 0, 0, 0);
    chk("t6_pre_rst_we", mem_write_enable, 1);
    do_reset();
    step(0, 0, 0, 30'h60, 0, 0);

    // Random traffic over a small address pool to exercise merges, wrap and flush.
    for (int n = 0; n < 800; n++) begin
      step(1'($urandom_range(0, 3) != 0), 30'($urandom_range(0, 7)), $urandom,
           30'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) == 0));
    end
    for (int n = 0; n < 6; n++) step(0, 0, 0, 0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
